tmon_alarm: RTL and testbench

Temperature alarm stage that sits directly downstream of `temp_sensor`, alongside `tmon_slave`. It consumes the same `tick`/`temp` sample stream and averages it over a 4-deep window. The average is classified against programmable high and low thresholds, with hysteresis and a debounce count. The block reports an alarm state, a one-cycle change event and a sticky latched flag that `tmon_slave` can expose over `tmon_bus`.

---
 rtl/tmon_alarm_if.sv | 24 ++
 rtl/tmon_alarm.sv | 188 ++++++++++++++++++
 tb/tb_tmon_alarm.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tmon_alarm_if.sv
// Sample stream in, averaged alarm status out, between temp_sensor and tmon_alarm.
interface tmon_alarm_if;
  logic       tick;
  logic [7:0] temp;
  logic [7:0] hi_thresh;
  logic [7:0] lo_thresh;
  logic       clr;
  logic [7:0] avg;
  logic       avg_valid;
  logic [1:0] state;
  logic       alarm;
  logic       evt;
  logic       sticky;

  modport master (
    output tick, temp, hi_thresh, lo_thresh, clr,
    input  avg, avg_valid, state, alarm, evt, sticky
  );

  modport slave (
    input  tick, temp, hi_thresh, lo_thresh, clr,
    output avg, avg_valid, state, alarm, evt, sticky
  );
endinterface

// File: rtl/tmon_alarm.sv
// Windowed temperature average with debounced, hysteretic HOT/COLD alarm classification.
// avg/avg_valid at tick+1, state/alarm/evt/sticky at tick+2; no backpressure, one sample per cycle.
module tmon_alarm #(
  parameter int AVG_DEPTH = 4,
  parameter int DEBOUNCE  = 3,
  parameter int HYST      = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  tmon_alarm_if.slave mon
);

  localparam int LOG2   = $clog2(AVG_DEPTH);
  localparam int SUM_W  = 8 + LOG2;
  localparam int FILL_W = $clog2(AVG_DEPTH + 1);
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_HOT    = 2'd1,
    ST_COLD   = 2'd2
  } state_e;

  // Sample stage
  logic [7:0]        win_q [AVG_DEPTH];
  logic [7:0]        win_d [AVG_DEPTH];
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              tick_q;

  // Average stage
  logic [7:0]        avg_q;
  logic              avg_valid_q;
  logic              eval_q;
  logic              full;

  // Classification stage
  state_e            state_q, state_d;
  state_e            dir_q, dir_d;
  state_e            tgt;
  logic              qual;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_n;
  logic              evt_q, evt_d;
  logic              sticky_q, sticky_d;
  logic [8:0]        hi_diff;
  logic [8:0]        lo_sum;
  logic [7:0]        hi_floor;
  logic [7:0]        lo_ceil;

  assign full = (fill_q == FILL_W'(AVG_DEPTH));

  always_comb begin
    win_d  = win_q;
    sum_d  = sum_q;
    fill_d = fill_q;
    if (mon.tick) begin
      win_d[0] = mon.temp;
      for (int i = 1; i < AVG_DEPTH; i++) begin
        win_d[i] = win_q[i-1];
      end
      sum_d = sum_q + SUM_W'(mon.temp) - SUM_W'(win_q[AVG_DEPTH-1]);
      if (!full) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < AVG_DEPTH; i++) begin
        win_q[i] <= '0;
      end
      sum_q  <= '0;
      fill_q <= '0;
      tick_q <= 1'b0;
    end else begin
      win_q  <= win_d;
      sum_q  <= sum_d;
      fill_q <= fill_d;
      tick_q <= mon.tick;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      eval_q      <= 1'b0;
    end else begin
      if (tick_q) begin
        avg_q       <= sum_q[SUM_W-1:LOG2];
        avg_valid_q <= full;
      end
      eval_q <= tick_q && full;
    end
  end

  // Exit margins saturate at the 8-bit range limits.
  assign hi_diff  = {1'b0, mon.hi_thresh} - 9'(HYST);
  assign lo_sum   = {1'b0, mon.lo_thresh} + 9'(HYST);
  assign hi_floor = hi_diff[8] ? 8'd0 : hi_diff[7:0];
  assign lo_ceil  = lo_sum[8] ? 8'hFF : lo_sum[7:0];

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    cnt_n    = '0;
    evt_d    = 1'b0;
    sticky_d = sticky_q;
    qual     = 1'b0;
    tgt      = ST_NORMAL;

    case (state_q)
      ST_NORMAL: begin
        if (avg_q > mon.hi_thresh) begin
          qual = 1'b1;
          tgt  = ST_HOT;
        end else if (avg_q < mon.lo_thresh) begin
          qual = 1'b1;
          tgt  = ST_COLD;
        end
      end
      ST_HOT: begin
        if (avg_q <= hi_floor) begin
          qual = 1'b1;
          tgt  = ST_NORMAL;
        end
      end
      ST_COLD: begin
        if (avg_q >= lo_ceil) begin
          qual = 1'b1;
          tgt  = ST_NORMAL;
        end
      end
      default: begin
        state_d = ST_NORMAL;
      end
    endcase

    if (eval_q) begin
      if (!qual) begin
        cnt_d = '0;
      end else begin
        // A new direction restarts the run with this evaluation as its first.
        cnt_n = (tgt == dir_q) ? cnt_q + CNT_W'(1) : CNT_W'(1);
        dir_d = tgt;
        if (cnt_n == CNT_W'(DEBOUNCE)) begin
          state_d = tgt;
          cnt_d   = '0;
          evt_d   = 1'b1;
        end else begin
          cnt_d = cnt_n;
        end
      end
    end

    if (evt_d && (state_d != ST_NORMAL)) begin
      sticky_d = 1'b1;
    end else if (mon.clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_NORMAL;
      dir_q    <= ST_NORMAL;
      cnt_q    <= '0;
      evt_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      evt_q    <= evt_d;
      sticky_q <= sticky_d;
    end
  end

  assign mon.avg       = avg_q;
  assign mon.avg_valid = avg_valid_q;
  assign mon.state     = state_q;
  assign mon.alarm     = (state_q != ST_NORMAL);
  assign mon.evt       = evt_q;
  assign mon.sticky    = sticky_q;

endmodule

// File: tb/tb_tmon_alarm.sv
// Bench for tmon_alarm: directed test-plan scenarios plus randomized traffic against a reference model.
module tb_tmon_alarm;
  localparam int AVG_DEPTH = 4;
  localparam int DEBOUNCE  = 3;
  localparam int HYST      = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tmon_alarm_if bus ();

  tmon_alarm #(
    .AVG_DEPTH(AVG_DEPTH),
    .DEBOUNCE (DEBOUNCE),
    .HYST     (HYST)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .mon  (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: samples kept as a list, averages and streaks derived from the rules.
  int m_win[$];
  int m_avg, m_valid, m_state, m_evt, m_sticky;
  bit m_eval_pend, m_tick_prev;
  int run_tgt, run_len;

  function automatic void model_reset();
    m_win.delete();
    m_avg = 0; m_valid = 0; m_state = 0; m_evt = 0; m_sticky = 0;
    m_eval_pend = 0; m_tick_prev = 0; run_tgt = -1; run_len = 0;
  endfunction

  function automatic void model_edge(bit tk, int t, bit c, int hi, int lo);
    int tgt, s, floor_v, ceil_v;
    bit entry;
    m_evt = 0;
    entry = 0;
    if (m_eval_pend) begin
      tgt     = -1;
      floor_v = (hi - HYST < 0) ? 0 : hi - HYST;
      ceil_v  = (lo + HYST > 255) ? 255 : lo + HYST;
      if (m_state == 0) begin
        if (m_avg > hi) tgt = 1;
        else if (m_avg < lo) tgt = 2;
      end else if (m_state == 1) begin
        if (m_avg <= floor_v) tgt = 0;
      end else begin
        if (m_avg >= ceil_v) tgt = 0;
      end
      if (tgt < 0) begin
        run_len = 0;
      end else begin
        if (tgt == run_tgt && run_len > 0) run_len++;
        else begin run_tgt = tgt; run_len = 1; end
        if (run_len >= DEBOUNCE) begin
          m_state = tgt; m_evt = 1; entry = (tgt != 0); run_len = 0; run_tgt = -1;
        end
      end
    end
    if (entry) m_sticky = 1;
    else if (c) m_sticky = 0;
    m_eval_pend = 0;
    if (m_tick_prev) begin
      s = 0;
      foreach (m_win[i]) s += m_win[i];
      m_avg       = s / AVG_DEPTH;
      m_valid     = (m_win.size() == AVG_DEPTH) ? 1 : 0;
      m_eval_pend = (m_valid == 1);
    end
    if (tk) begin
      m_win.push_back(t);
      if (m_win.size() > AVG_DEPTH) void'(m_win.pop_front());
    end
    m_tick_prev = tk;
  endfunction

  task automatic step(input bit tk, input int t, input bit c);
    @(negedge clk);
    bus.tick = tk;
    bus.temp = 8'(t);
    bus.clr  = c;
    @(posedge clk);
    model_edge(tk, t, c, int'(bus.hi_thresh), int'(bus.lo_thresh));
    #1;
    bus.tick = 1'b0;
    bus.clr  = 1'b0;
  endtask

  task automatic sample_full(input int t);
    step(1'b1, t, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
  endtask

  task automatic set_thr(input int hi, input int lo);
    bus.hi_thresh = 8'(hi);
    bus.lo_thresh = 8'(lo);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.tick = 1'b0; bus.temp = 8'd0; bus.clr = 1'b0;
    set_thr(255, 0);
    model_reset();
    #3;
    total++;
    if (bus.avg !== 8'd0 || bus.avg_valid !== 1'b0) begin
      bad++; $display("FAIL reset_avg: got avg=%0d valid=%b want 0/0", bus.avg, bus.avg_valid);
    end
    total++;
    if (bus.state !== 2'd0 || bus.alarm !== 1'b0 || bus.evt !== 1'b0 || bus.sticky !== 1'b0) begin
      bad++; $display("FAIL reset_state: got state=%0d alarm=%b evt=%b sticky=%b want all 0",
                      bus.state, bus.alarm, bus.evt, bus.sticky);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_window_fill();
    int temps[4] = '{10, 20, 30, 40};
    do_reset();
    set_thr(255, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, temps[i], 1'b0);
      total++;
      if (bus.avg_valid !== 1'b0) begin
        bad++; $display("FAIL fill_valid_early[%0d]: got %b want 0", i, bus.avg_valid);
      end
    end
    step(1'b0, 0, 1'b0);
    total++;
    if (bus.avg !== 8'd25 || bus.avg_valid !== 1'b1) begin
      bad++; $display("FAIL fill_first_avg: got avg=%0d valid=%b want 25/1", bus.avg, bus.avg_valid);
    end
    step(1'b1, 50, 1'b0);
    step(1'b0, 0, 1'b0);
    total++;
    if (bus.avg !== 8'd35) begin
      bad++; $display("FAIL fill_slide_avg: got %0d want 35", bus.avg);
    end
  endtask

  task automatic test_hot_entry();
    do_reset();
    set_thr(80, 20);
    for (int i = 0; i < 3; i++) step(1'b1, 100, 1'b0);
    for (int n = 1; n <= 3; n++) begin
      step(1'b1, 100, 1'b0);
      step(1'b0, 0, 1'b0);
      total++;
      if (bus.state !== 2'd0) begin
        bad++; $display("FAIL hot_latency[%0d]: got state=%0d want 0", n, bus.state);
      end
      step(1'b0, 0, 1'b0);
      total++;
      if (n < 3) begin
        if (bus.state !== 2'd0 || bus.evt !== 1'b0) begin
          bad++; $display("FAIL hot_debounce[%0d]: got state=%0d evt=%b want 0/0", n, bus.state, bus.evt);
        end
      end else begin
        if (bus.state !== 2'd1 || bus.evt !== 1'b1 || bus.alarm !== 1'b1 || bus.sticky !== 1'b1) begin
          bad++; $display("FAIL hot_entry: got state=%0d evt=%b alarm=%b sticky=%b want 1/1/1/1",
                          bus.state, bus.evt, bus.alarm, bus.sticky);
        end
      end
    end
    step(1'b0, 0, 1'b0);
    total++;
    if (bus.evt !== 1'b0 || bus.state !== 2'd1) begin
      bad++; $display("FAIL hot_evt_pulse: got evt=%b state=%0d want 0/1", bus.evt, bus.state);
    end
  endtask

  task automatic test_debounce_break();
    int temps[6] = '{90, 90, 10, 170, 90, 90};
    int avgs[6]  = '{90, 90, 70, 90, 90, 90};
    do_reset();
    set_thr(80, 20);
    for (int i = 0; i < 3; i++) step(1'b1, 90, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, temps[i], 1'b0);
      step(1'b0, 0, 1'b0);
      total++;
      if (bus.avg !== 8'(avgs[i])) begin
        bad++; $display("FAIL break_avg[%0d]: got %0d want %0d", i, bus.avg, avgs[i]);
      end
      step(1'b0, 0, 1'b0);
      total++;
      if (i < 5) begin
        if (bus.state !== 2'd0 || bus.evt !== 1'b0) begin
          bad++; $display("FAIL break_hold[%0d]: got state=%0d evt=%b want 0/0", i, bus.state, bus.evt);
        end
      end else if (bus.state !== 2'd1 || bus.evt !== 1'b1) begin
        bad++; $display("FAIL break_enter: got state=%0d evt=%b want 1/1", bus.state, bus.evt);
      end
    end
  endtask

  task automatic test_hysteresis_exit();
    for (int i = 0; i < 4; i++) sample_full(79);
    for (int i = 0; i < 6; i++) begin
      sample_full(79);
      total++;
      if (bus.avg !== 8'd79 || bus.state !== 2'd1) begin
        bad++; $display("FAIL hyst_hold[%0d]: got avg=%0d state=%0d want 79/1", i, bus.avg, bus.state);
      end
    end
    for (int i = 0; i < 3; i++) begin
      sample_full(78);
      total++;
      if (i < 2) begin
        if (bus.avg !== 8'd78 || bus.state !== 2'd1) begin
          bad++; $display("FAIL hyst_count[%0d]: got avg=%0d state=%0d want 78/1", i, bus.avg, bus.state);
        end
      end else if (bus.state !== 2'd0 || bus.evt !== 1'b1 || bus.sticky !== 1'b1 || bus.alarm !== 1'b0) begin
        bad++; $display("FAIL hyst_exit: got state=%0d evt=%b sticky=%b alarm=%b want 0/1/1/0",
                        bus.state, bus.evt, bus.sticky, bus.alarm);
      end
    end
  endtask

  task automatic test_sticky_clr();
    step(1'b0, 0, 1'b1);
    total++;
    if (bus.sticky !== 1'b0 || bus.state !== 2'd0) begin
      bad++; $display("FAIL clr_alone: got sticky=%b state=%0d want 0/0", bus.sticky, bus.state);
    end
    set_thr(80, 20);
    for (int i = 0; i < 5; i++) sample_full(5);
    step(1'b1, 5, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1);
    total++;
    if (bus.state !== 2'd2 || bus.evt !== 1'b1 || bus.sticky !== 1'b1) begin
      bad++; $display("FAIL clr_vs_entry: got state=%0d evt=%b sticky=%b want 2/1/1", bus.state, bus.evt, bus.sticky);
    end
    step(1'b0, 0, 1'b1);
    total++;
    if (bus.sticky !== 1'b0 || bus.state !== 2'd2) begin
      bad++; $display("FAIL clr_keeps_state: got sticky=%b state=%0d want 0/2", bus.sticky, bus.state);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) sample_full(200);
    total++;
    if (bus.state !== 2'd1) begin
      bad++; $display("FAIL arst_setup: got state=%0d want 1", bus.state);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.avg, bus.avg_valid, bus.state, bus.alarm, bus.evt, bus.sticky} !== 14'd0) begin
      bad++; $display("FAIL arst_clear: got avg=%0d valid=%b state=%0d alarm=%b evt=%b sticky=%b want all 0",
                      bus.avg, bus.avg_valid, bus.state, bus.alarm, bus.evt, bus.sticky);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_full(100);
      total++;
      if (bus.avg_valid !== 1'b0 || bus.state !== 2'd0) begin
        bad++; $display("FAIL arst_refill[%0d]: got valid=%b state=%0d want 0/0", i, bus.avg_valid, bus.state);
      end
    end
    step(1'b1, 100, 1'b0);
    step(1'b0, 0, 1'b0);
    total++;
    if (bus.avg_valid !== 1'b1 || bus.avg !== 8'd100) begin
      bad++; $display("FAIL arst_full: got valid=%b avg=%0d want 1/100", bus.avg_valid, bus.avg);
    end
  endtask

  task automatic test_random_back_to_back();
    int level, t, hi, lo;
    bit tk, c;
    do_reset();
    for (int ph = 0; ph < 60; ph++) begin
      if (ph == 30) do_reset();
      case ($urandom_range(0, 5))
        0:       begin hi = 0;   lo = 255; end
        1:       begin hi = 255; lo = 0;   end
        2:       begin hi = 1;   lo = 254; end
        default: begin hi = $urandom_range(60, 200); lo = $urandom_range(20, hi); end
      endcase
      set_thr(hi, lo);
      level = $urandom_range(0, 255);
      for (int k = 0; k < 30; k++) begin
        tk = ($urandom_range(0, 3) != 0);
        t  = level + $urandom_range(0, 20) - 10;
        if (t < 0) t = 0;
        if (t > 255) t = 255;
        c  = ($urandom_range(0, 15) == 0);
        step(tk, t, c);
        total++;
        if (bus.avg !== 8'(m_avg) || bus.avg_valid !== m_valid[0]) begin
          bad++; $display("FAIL rand_avg ph%0d k%0d: got avg=%0d valid=%b want %0d/%0d",
                          ph, k, bus.avg, bus.avg_valid, m_avg, m_valid);
        end
        total++;
        if (bus.state !== 2'(m_state) || bus.evt !== m_evt[0] || bus.sticky !== m_sticky[0] ||
            bus.alarm !== (m_state != 0)) begin
          bad++; $display("FAIL rand_class ph%0d k%0d: got state=%0d evt=%b sticky=%b alarm=%b want %0d/%0d/%0d/%0d",
                          ph, k, bus.state, bus.evt, bus.sticky, bus.alarm, m_state, m_evt, m_sticky,
                          (m_state != 0));
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_window_fill();
    test_hot_entry();
    test_debounce_break();
    test_hysteresis_exit();
    test_sticky_clr();
    test_async_reset();
    test_random_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
